uart_rx_baud: RTL and testbench
===============================

# uart_rx_baud

UART receiver with an integrated baud-rate tick generator. It deserialises 8N1 frames from the host link into bytes for the command/program loader of the MIPS debug unit. It sits between the board `rx` pin and the debug-unit byte interface. It also exports the oversampling tick so a companion transmitter can share it.

## Interface
Parameters:
- `N`, 8: data bits per frame.
- `COUNT_TICKS`, 16: oversampling ticks per bit.
- `COUNT`, 326: clock cycles per tick (100 MHz / 326 / 16 ≈ 19200 baud).

Ports:
- `clk`, in, 1: single system clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `rx`, in, 1: serial input, idle high.
- `tick`, out, 1: one-cycle oversampling strobe.
- `data_out`, out, N: last correctly received byte.
- `valid`, out, 1: one-cycle pulse when `data_out` is updated.
- `state_leds`, out, 4: one-hot FSM state {STOP, DATA, START, IDLE} (bit0 = IDLE).
- `started`, out, 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Baud generator:
  - Counter runs 0..COUNT-1 and wraps.
  - `tick` = 1 for exactly the one cycle in which the counter equals COUNT-1.
  - Free-running from reset release, independent of the FSM.
- Receiver FSM, with a sample counter `s` (4 bit), bit counter `n` (log2 N), and shift register `b` (N bit):
  - IDLE: when `rx` = 0 (sampled every clk, not tick-gated), go to START with s=0.
  - START: on each tick, s++. When s = COUNT_TICKS/2-1 (7), the bit midpoint is reached:
    - If `rx` = 0: s=0, n=0, go to DATA.
    - If `rx` = 1: false start; go to IDLE with no output.
  - DATA: on each tick, s++. When s = COUNT_TICKS-1 (15):
    - s=0, and `b` = {rx, b[N-1:1]} (LSB first).
    - If n = N-1, go to STOP; else n++.
  - STOP: on each tick, s++. When s = COUNT_TICKS-1:
    - If `rx` = 1: `data_out` ← `b`, `valid` pulses, go to IDLE.
    - If `rx` = 0 (framing error): frame dropped, `data_out` unchanged, no `valid`, go to IDLE.
  - Non-tick cycles leave s, n and b unchanged.
- `data_out` holds its value until the next good frame.
- `valid` is never asserted for more than one cycle per frame.
- Reset (any time, including mid-frame):
  - FSM → IDLE; s, n, b, baud counter → 0.
  - `data_out` = 0, `valid` = 0, `tick` = 0, `state_leds` = 4'b0001, `started` = 0.
  - Frame in progress is discarded.

## Timing
- Tick period: exactly COUNT clocks.
- Start edge to first data-bit sample: 8 + 16 ticks after the start detection, i.e. the mid-bit of bit 0.
- Each subsequent data-bit sample: 16 ticks apart.
- `valid` and `data_out`: registered, asserted in the clk cycle after the tick edge that completes the stop bit. This is ≈ 8+16·N+16 ticks after the falling start edge (≈ 152 ticks, ≈ 49.5k clocks at defaults).
- `state_leds` and `started` are registered and change on the same edge as the FSM state.
- Back-to-back frames: the FSM is in IDLE half a bit before the stop bit ends, so a start edge immediately after a stop bit is detected with no lost frames.
- Async reset takes effect without a clock. Release is synchronous to the next rising `clk` edge.

## Test plan
- Reset low, then high. Check: `data_out` = 0, `valid` = 0, `state_leds` = 0001, `started` = 0. Then `tick` pulses every 326 clocks, one cycle wide.
- Send 0x08 at 16·326 clocks per bit → exactly one `valid` pulse, `data_out` = 0x08, `started` high only during the frame.
- Send 0xA5, then 0x3C back-to-back (no idle gap) → two `valid` pulses with 0xA5 then 0x3C; `data_out` holds 0x3C afterward.
- Drive `rx` low for 5 ticks, then high → START entered, returns to IDLE, no `valid`, `data_out` unchanged.
- Send 0x55 with the stop bit forced low → no `valid`, `data_out` keeps the previous byte. A following good 0x0E frame is received correctly.
- Assert reset during DATA of a 0xFF frame, then send 0x07 → no output from the aborted frame; 0x07 received with a single `valid`.

Source files
------------

// File: rtl/uart_rx_baud.sv
// uart_rx_baud: 8N1 UART receiver with built-in oversampling baud tick.
// Feeds received bytes to the MIPS debug-unit loader; tick is exported.
//
// Ports:
//   clk        system clock, rising edge
//   reset      async active-low reset
//   rx         serial input, idle high
//   tick       one-cycle oversampling strobe (every COUNT clocks)
//   data_out   last good byte, held until the next good frame
//   valid      one-cycle pulse when data_out is updated
//   state_leds one-hot FSM state {STOP, DATA, START, IDLE}
//   started    high while a frame is in progress
module uart_rx_baud #(
  parameter int N           = 8,
  parameter int COUNT_TICKS = 16,
  parameter int COUNT       = 326
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx,
  output logic         tick,
  output logic [N-1:0] data_out,
  output logic         valid,
  output logic [3:0]   state_leds,
  output logic         started
);

  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(COUNT - 1);
  localparam logic [3:0]    S_MID  = 4'(COUNT_TICKS / 2 - 1);
  localparam logic [3:0]    S_END  = 4'(COUNT_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);

  // One-hot encoding doubles as the LED pattern.
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;

  logic [CW-1:0] cnt;

  state_t        state, state_nx;
  logic [3:0]    s, s_nx;
  logic [NW-1:0] n, n_nx;
  logic [N-1:0]  b, b_nx;
  logic          valid_nx;
  logic          started_q;

  // Baud generator: free-running, independent of the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == C_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == C_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      b         <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state     <= state_nx;
      s         <= s_nx;
      n         <= n_nx;
      b         <= b_nx;
      valid     <= valid_nx;
      started_q <= (state_nx != IDLE);
      if (valid_nx) begin
        data_out <= b;
      end
    end
  end

  always_comb begin
    state_nx = state;
    s_nx     = s;
    n_nx     = n;
    b_nx     = b;
    valid_nx = 1'b0;
    unique case (state)
      IDLE: begin
        // Start edge is seen on any clock, not just ticks.
        if (!rx) begin
          state_nx = START;
          s_nx     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s == S_MID) begin
            // Mid start bit: still low means a real frame.
            if (!rx) begin
              s_nx     = '0;
              n_nx     = '0;
              state_nx = DATA;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            s_nx = s + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == S_END) begin
            s_nx = '0;
            b_nx = {rx, b[N-1:1]};
            if (n == N_LAST) begin
              state_nx = STOP;
            end else begin
              n_nx = n + NW'(1);
            end
          end else begin
            s_nx = s + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == S_END) begin
            // Low stop bit is a framing error: drop the byte.
            s_nx     = '0;
            valid_nx = rx;
            state_nx = IDLE;
          end else begin
            s_nx = s + 4'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign state_leds = state;
  assign started    = started_q;

endmodule

// File: tb/tb_uart_rx_baud.sv
// tb_uart_rx_baud: directed frames with a byte scoreboard.
// A shortened tick period keeps each frame to a few hundred clocks.
module tb_uart_rx_baud;

  localparam int TC   = 4;
  localparam int BITC = 16 * TC;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       tick;
  logic [7:0] data_out;
  logic       valid;
  logic [3:0] state_leds;
  logic       started;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic       prev_v = 1'b0;

  uart_rx_baud #(
    .N(8),
    .COUNT_TICKS(16),
    .COUNT(TC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .tick(tick),
    .data_out(data_out),
    .valid(valid),
    .state_leds(state_leds),
    .started(started)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the next queued byte.
  always @(negedge clk) begin
    if (reset && valid) begin
      total++;
      if (prev_v) begin
        bad++;
        $display("FAIL valid_width got=2+ cycles want=1");
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid got=%0h want=none", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          bad++;
          $display("FAIL rx_byte got=%0h want=%0h", data_out, e);
        end
      end
    end
    prev_v = reset && valid;
  end

  task automatic idle_bits(input int nb);
    rx = 1'b1;
    repeat (nb * BITC) @(negedge clk);
  endtask

  task automatic send_frame(
    input logic [7:0] d,
    input logic       stop_v,
    input int         stop_clk,
    input bit         probe
  );
    rx = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BITC) @(negedge clk);
      if (probe && i == 2) begin
        chk("started_mid", int'(started), 1);
        chk("leds_data", int'(state_leds), 4'b0100);
      end
    end
    rx = stop_v;
    repeat (stop_clk) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    int k;
    rx    = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", int'(data_out), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_leds", int'(state_leds), 4'b0001);
    chk("rst_started", int'(started), 0);
    chk("rst_tick", int'(tick), 0);
    reset = 1'b1;

    // Tick period and width.
    k = 0;
    while (!tick && k < 2 * TC) begin
      @(negedge clk);
      k++;
    end
    chk("tick_seen", int'(tick), 1);
    @(negedge clk);
    chk("tick_width", int'(tick), 0);
    k = 1;
    while (!tick && k < 2 * TC) begin
      @(negedge clk);
      k++;
    end
    chk("tick_period", k, TC);

    // Single frame 0x08.
    idle_bits(1);
    exp_q.push_back(8'h08);
    send_frame(8'h08, 1'b1, BITC, 1'b1);
    idle_bits(1);
    chk("q_08", exp_q.size(), 0);
    chk("data_08", int'(data_out), 8'h08);
    chk("started_end", int'(started), 0);
    chk("leds_idle", int'(state_leds), 4'b0001);

    // Back-to-back 0xA5, 0x3C.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1, BITC, 1'b0);
    send_frame(8'h3C, 1'b1, BITC, 1'b0);
    idle_bits(1);
    chk("q_b2b", exp_q.size(), 0);
    chk("data_3c", int'(data_out), 8'h3C);

    // False start: low for 5 ticks only.
    rx = 1'b0;
    repeat (5 * TC) @(negedge clk);
    chk("fs_leds", int'(state_leds), 4'b0010);
    chk("fs_started", int'(started), 1);
    idle_bits(1);
    chk("fs_back_idle", int'(state_leds), 4'b0001);
    chk("fs_data", int'(data_out), 8'h3C);

    // Framing error on 0x55, then good 0x0E.
    send_frame(8'h55, 1'b0, 12 * TC, 1'b0);
    idle_bits(2);
    chk("fe_data", int'(data_out), 8'h3C);
    chk("fe_leds", int'(state_leds), 4'b0001);
    exp_q.push_back(8'h0E);
    send_frame(8'h0E, 1'b1, BITC, 1'b0);
    idle_bits(1);
    chk("q_0e", exp_q.size(), 0);
    chk("data_0e", int'(data_out), 8'h0E);

    // Reset mid-DATA of 0xFF, then 0x07.
    rx = 1'b0;
    repeat (BITC) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BITC) @(negedge clk);
    chk("pre_rst_leds", int'(state_leds), 4'b0100);
    reset = 1'b0;
    #1;
    chk("arst_leds", int'(state_leds), 4'b0001);
    chk("arst_started", int'(started), 0);
    chk("arst_data", int'(data_out), 0);
    chk("arst_valid", int'(valid), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_bits(6);
    chk("abort_data", int'(data_out), 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, BITC, 1'b0);
    idle_bits(1);
    chk("q_07", exp_q.size(), 0);
    chk("data_07", int'(data_out), 8'h07);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
